matmul_stream: RTL and testbench
================================

// Module: matmul_stream
// PURPOSE
// - Parametrised sequential signed NxN matrix multiplier, Res = A x B; successor to the fixed 2x2 Mat_mult.
// - Adds valid/ready handshakes, reset, Qm.FRAC fixed-point scaling and saturate/wrap mode.
// - Sits between coefficient sources (cossin, div IP outputs) and downstream transform logic.
// - Single time-shared MAC: one product per cycle.
// PARAMETERS
// - N      2   matrix dimension, legal 2..8
// - W      32  element width, two's complement
// - FRAC   0   fractional bits; result = (sum of products) >>> FRAC, arithmetic shift
// - SAT    1   1: saturate result to W bits; 0: wrap (keep low W bits)
// - ACC_W  2*W+$clog2(N)  accumulator width, derived localparam, must not be overridden
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      A/B operands valid
// - in_ready   out  1      block idle, can accept operands
// - A          in   N*N*W  packed row-major; element (r,c) at [(N*N-1-(r*N+c))*W +: W], so (0,0) is MSB
// - B          in   N*N*W  same packing as A
// - out_valid  out  1      Res valid
// - out_ready  in   1      downstream accepts Res
// - Res        out  N*N*W  product, same packing as A
// - ovf        out  1      at least one element saturated (SAT=1) or wrapped (SAT=0) in this Res
// BEHAVIOUR
// - Reset (async assert, sync-safe release):
//   - state=IDLE; in_ready=1; out_valid=0; Res=0; ovf=0.
//   - Counters and accumulator cleared.
// - FSM IDLE -> COMPUTE -> DONE -> IDLE.
// - IDLE:
//   - in_ready=1.
//   - in_valid && in_ready at a clock edge latches A and B into internal registers, clears i,j,k,acc and enters COMPUTE.
// - COMPUTE:
//   - in_ready=0.
//   - Each cycle: acc_next = acc + a[i][k]*b[k][j], product full 2W signed.
//   - Loop nesting: k innermost, then j, then i.
//   - When k==N-1, element (i,j) is written and acc is cleared:
//     - value = acc_next >>> FRAC
//     - SAT=1: clamp to [-2^(W-1), 2^(W-1)-1]; SAT=0: keep low W bits.
//     - ovf is set (sticky per transaction) if value lies outside the W-bit range.
// - Timing: exactly N^3 COMPUTE cycles; out_valid rises on the edge N^3 cycles after the accept edge.
// - DONE:
//   - out_valid=1; Res and ovf held stable while out_ready=0.
//   - out_valid && out_ready: out_valid->0 and return to IDLE; in_ready=1 from the next cycle.
//   - No overlap: a new operand set is never accepted in the same cycle as output handoff.
// - Res is updated element by element during COMPUTE; consumers must sample only when out_valid=1.
// - Signals not held:
//   - Operand ports are not required to stay stable after acceptance.
//   - in_valid is ignored outside IDLE.
// - rst_n asserted mid-COMPUTE or mid-DONE aborts immediately; the transaction is lost and all outputs take reset values.
// - A pending out_valid with in_valid high does not stall the FSM; in_valid simply waits.
// - Rounding: truncation toward -inf (arithmetic shift); no round-to-nearest.
// - Accumulator cannot overflow (ACC_W covers N products); overflow is judged only after the shift.
// STRUCTURE
// - matmul_defs.vh (shared include):
//   - FSM state encodings S_IDLE=2'd0, S_COMPUTE=2'd1, S_DONE=2'd2
//   - elem index macro for row-major packing, shared with testbenches.
// - Sub-module matmul_mac:
//   - Registered signed W x W multiply-accumulate with clear input.
//   - Saturate/wrap + shift output stage.
//   - Parametrised by W, ACC_W, FRAC, SAT.
// - Top holds operand registers, i/j/k counters ($clog2(N) bits each), FSM and Res register file.
// TESTING
// - T1: N=2,W=32,FRAC=0; A={-1,2,3,4}, B={1,2,3,4}
//   -> Res={5,6,15,22}, ovf=0; out_valid exactly 8 cycles after accept.
// - T2: SAT=1; all elements of A and B = 32'h7FFFFFFF
//   -> every Res element = 32'h7FFFFFFF, ovf=1.
//   - Same stimulus with SAT=0 -> every element = 32'h00000002, ovf=1.
// - T3: FRAC=16; A=identity in Q16.16 (diag 32'h00010000), B={32'h00018000,-32'h00010000,32'h00000004,32'h7FFF0000}
//   -> Res==B, ovf=0.
// - T4: backpressure; hold out_ready=0 for 10 cycles after out_valid with in_valid=1 and new operands
//   -> Res, ovf, out_valid=1 stable and in_ready=0 throughout.
//   - out_ready=1 -> in_ready=1 the next cycle; second result correct.
// - T5: reset mid-operation; pulse rst_n low asynchronously 3 cycles into COMPUTE
//   -> out_valid=0, Res=0, in_ready=1 during reset.
//   - A subsequent T1 transaction completes correctly.
// - T6: N=4 random signed operands, 200 transactions with random in_valid/out_ready gaps
//   -> Res matches a behavioural model; latency always 64 cycles.

Source files
------------

// File: rtl/matmul_stream_pkg.sv
// matmul_stream_pkg: FSM state encodings and row-major element index helper shared by RTL and benches
package matmul_stream_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COMPUTE = 2'd1, S_DONE = 2'd2} state_t;
  function automatic int elem(input int n, input int r, input int c);
    return n * n - 1 - (r * n + c);
  endfunction
endpackage

// File: rtl/matmul_stream_if.sv
// matmul_stream_if: operand/result handshake bundle; master drives in_valid/a/b/out_ready, slave drives in_ready/out_valid/res/ovf
interface matmul_stream_if #(parameter int N = 2, parameter int W = 32);
  logic in_valid, in_ready, out_valid, out_ready, ovf;
  logic [N*N*W-1:0] a, b, res;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, res, ovf);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, res, ovf);
endinterface

// File: rtl/matmul_stream_mac.sv
// matmul_stream_mac: registered signed MAC with clear, shift and saturate/wrap output stage; ports clk, rst_n, clr, en, last, x, y in, val, of out
module matmul_stream_mac #(
  parameter int W = 32,
  parameter int ACC_W = 66,
  parameter int FRAC = 0,
  parameter int SAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic                last,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  output logic        [W-1:0] val,
  output logic                of
);
  localparam int PW = 2 * W;
  logic signed [PW-1:0] p;
  logic signed [ACC_W-1:0] acc, acc_next, sh;
  always_comb begin
    p = PW'(x) * PW'(y);
    acc_next = acc + ACC_W'(p);
    sh = acc_next >>> FRAC;
    of = !(&sh[ACC_W-1:W-1] || !(|sh[ACC_W-1:W-1]));
    val = (SAT != 0 && of) ? (sh[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sh[W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= last ? '0 : acc_next;
endmodule

// File: rtl/matmul_stream.sv
// matmul_stream: sequential signed NxN fixed-point matrix multiplier, one product per cycle; ports clk, rst_n, bus (slave: in_valid/a/b/out_ready in, in_ready/out_valid/res/ovf out)
module matmul_stream
  import matmul_stream_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 32,
  parameter int FRAC = 0,
  parameter int SAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  matmul_stream_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam int ACC_W = 2 * W + CW;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t st, nst;
  logic [CW-1:0] i, j, k;
  logic signed [W-1:0] am [N][N];
  logic signed [W-1:0] bm [N][N];
  logic take, en, last, fin, of;
  logic [W-1:0] val;
  assign take = bus.in_valid && bus.in_ready;
  assign last = k == LAST;
  assign fin = last && j == LAST && i == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= S_IDLE;
    else st <= nst;
  always_comb
    nst = st == S_IDLE ? (bus.in_valid ? S_COMPUTE : S_IDLE) :
          st == S_COMPUTE ? (fin ? S_DONE : S_COMPUTE) :
          st == S_DONE ? (bus.out_ready ? S_IDLE : S_DONE) : S_IDLE;
  always_comb begin
    bus.in_ready = st == S_IDLE;
    bus.out_valid = st == S_DONE;
    en = st == S_COMPUTE;
  end
  always_ff @(posedge clk)
    if (take)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          am[r][c] <= bus.a[elem(N, r, c) * W +: W];
          bm[r][c] <= bus.b[elem(N, r, c) * W +: W];
        end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
      bus.res <= '0;
      bus.ovf <= 1'b0;
    end else if (take) begin
      i <= '0;
      j <= '0;
      k <= '0;
      bus.ovf <= 1'b0;
    end else if (en) begin
      k <= last ? '0 : k + 1'b1;
      if (last) begin
        j <= j == LAST ? '0 : j + 1'b1;
        if (j == LAST) i <= i == LAST ? '0 : i + 1'b1;
        bus.res[elem(N, int'(i), int'(j)) * W +: W] <= val;
        bus.ovf <= bus.ovf | of;
      end
    end
  matmul_stream_mac #(.W(W), .ACC_W(ACC_W), .FRAC(FRAC), .SAT(SAT)) u_mac (
    .clk(clk), .rst_n(rst_n), .clr(take), .en(en), .last(last),
    .x(am[i][k]), .y(bm[k][j]), .val(val), .of(of)
  );
endmodule

// File: tb/tb_matmul_stream.sv
// tb_matmul_stream: directed vector table on three 2x2 configurations plus 4x4 randomized model check
module tb_matmul_stream;
  import matmul_stream_pkg::*;
  typedef struct {
    int sel;
    logic [127:0] a, b, res;
    logic ovf;
  } vec_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic in_valid = 0, out_ready = 0, in4_valid = 0, out4_ready = 0;
  logic [127:0] a = '0, b = '0;
  logic [511:0] a4 = '0, b4 = '0;
  int sel = 0, checks = 0, errors = 0;
  logic [127:0] r_o [3];
  logic iv [3], ov [3], of [3];
  matmul_stream_if #(.N(2), .W(32)) m [3] ();
  matmul_stream_if #(.N(4), .W(32)) m4 ();
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign m[g].in_valid = in_valid;
    assign m[g].out_ready = out_ready;
    assign m[g].a = a;
    assign m[g].b = b;
    assign r_o[g] = m[g].res;
    assign iv[g] = m[g].in_ready;
    assign ov[g] = m[g].out_valid;
    assign of[g] = m[g].ovf;
    matmul_stream #(.N(2), .W(32), .FRAC(g == 2 ? 16 : 0), .SAT(g == 1 ? 0 : 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(m[g])
    );
  end
  assign m4.in_valid = in4_valid;
  assign m4.out_ready = out4_ready;
  assign m4.a = a4;
  assign m4.b = b4;
  matmul_stream #(.N(4), .W(32), .FRAC(0), .SAT(1)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(m4));

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic xact(input int s, input logic [127:0] av, input logic [127:0] bv,
                      output logic [127:0] r, output logic o, output int lat);
    int t;
    sel = s;
    t = 0;
    @(negedge clk);
    while (!iv[sel] && t < 100) begin
      @(negedge clk);
      t++;
    end
    a = av;
    b = bv;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    a = ~av;
    b = ~bv;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!ov[sel] && lat < 200);
    r = r_o[sel];
    o = of[sel];
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  function automatic void model4(input logic [511:0] x, input logic [511:0] y,
                                 output logic [511:0] r, output logic o);
    logic signed [67:0] s, p, q;
    r = '0;
    o = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++) begin
          p = {{36{x[elem(4, i, k) * 32 + 31]}}, x[elem(4, i, k) * 32 +: 32]};
          q = {{36{y[elem(4, k, j) * 32 + 31]}}, y[elem(4, k, j) * 32 +: 32]};
          s = s + p * q;
        end
        if (s > 68'sd2147483647) begin
          r[elem(4, i, j) * 32 +: 32] = 32'h7FFFFFFF;
          o = 1;
        end else if (s < -68'sd2147483648) begin
          r[elem(4, i, j) * 32 +: 32] = 32'h80000000;
          o = 1;
        end else r[elem(4, i, j) * 32 +: 32] = s[31:0];
      end
  endfunction

  initial begin
    vec_t v [10];
    logic [127:0] r;
    logic o, ok;
    logic [511:0] e4, r4;
    logic eo, o4;
    logic [31:0] rv;
    int lat, mode, t;
    v[0] = '{0, {32'hFFFFFFFF, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd15, 32'd22}, 1'b0};
    v[1] = '{0, {4{32'h7FFFFFFF}}, {4{32'h7FFFFFFF}}, {4{32'h7FFFFFFF}}, 1'b1};
    v[2] = '{1, {4{32'h7FFFFFFF}}, {4{32'h7FFFFFFF}}, {4{32'd2}}, 1'b1};
    v[3] = '{2, {32'h00010000, 32'd0, 32'd0, 32'h00010000}, {32'h00018000, 32'hFFFF0000, 32'd4, 32'h7FFF0000},
             {32'h00018000, 32'hFFFF0000, 32'd4, 32'h7FFF0000}, 1'b0};
    v[4] = '{0, {32'hFFFFFFFE, 32'd0, 32'd5, 32'hFFFFFFFD}, {32'd7, 32'hFFFFFFFF, 32'd2, 32'd4},
             {32'hFFFFFFF2, 32'd2, 32'd29, 32'hFFFFFFEF}, 1'b0};
    v[5] = '{0, {32'h80000000, 32'h80000000, 32'd0, 32'd1}, {32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd3},
             {32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'd3}, 1'b1};
    v[6] = '{0, {32'h80000000, 32'd0, 32'd0, 32'd1}, {32'd1, 32'd0, 32'd0, 32'h7FFFFFFF},
             {32'h80000000, 32'd0, 32'd0, 32'h7FFFFFFF}, 1'b0};
    v[7] = '{2, {32'h00008000, 32'd0, 32'd0, 32'hFFFF8000}, {32'd3, 32'd0, 32'd0, 32'd3},
             {32'd1, 32'd0, 32'd0, 32'hFFFFFFFE}, 1'b0};
    v[8] = '{1, {32'h80000000, 32'd0, 32'd0, 32'd0}, {32'd2, 32'd0, 32'd0, 32'd0}, 128'd0, 1'b1};
    v[9] = '{1, {32'hFFFFFFFF, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd15, 32'd22}, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_in_ready%0d", g), iv[g], 1);
      chk($sformatf("rst_out_valid%0d", g), ov[g], 0);
      chk($sformatf("rst_res%0d", g), r_o[g], 0);
      chk($sformatf("rst_ovf%0d", g), of[g], 0);
    end
    chk("rst_n4_res", m4.res, 0);
    @(negedge clk) rst_n = 1;
    for (int n = 0; n < 10; n++) begin
      xact(v[n].sel, v[n].a, v[n].b, r, o, lat);
      chk($sformatf("vec%0d_res", n), r, v[n].res);
      chk($sformatf("vec%0d_ovf", n), o, v[n].ovf);
      chk($sformatf("vec%0d_lat", n), lat, 8);
    end
    sel = 0;
    @(negedge clk);
    a = v[0].a;
    b = v[0].b;
    in_valid = 1;
    @(posedge clk);
    #1 a = v[4].a;
    b = v[4].b;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!ov[0] && lat < 200);
    chk("bp_lat1", lat, 8);
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (r_o[0] !== v[0].res || of[0] !== 0 || ov[0] !== 1 || iv[0] !== 0) ok = 0;
    end
    chk("bp_hold", ok, 1);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("bp_ready_after", iv[0], 1);
    chk("bp_valid_after", ov[0], 0);
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!ov[0] && lat < 200);
    chk("bp_lat2", lat, 8);
    chk("bp_res2", r_o[0], v[4].res);
    chk("bp_ovf2", of[0], 0);
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    a = v[0].a;
    b = v[0].b;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_res", r_o[0], 0);
    chk("mid_rst_ready", iv[0], 1);
    chk("mid_rst_ovf", of[0], 0);
    @(negedge clk) rst_n = 1;
    xact(0, v[0].a, v[0].b, r, o, lat);
    chk("post_rst_res", r, v[0].res);
    chk("post_rst_ovf", o, 0);
    chk("post_rst_lat", lat, 8);
    for (int n = 0; n < 200; n++) begin
      mode = $urandom_range(0, 3);
      for (int e = 0; e < 16; e++) begin
        rv = $urandom;
        a4[e*32 +: 32] = mode == 0 ? {{24{rv[7]}}, rv[7:0]} : mode == 1 ? {{16{rv[15]}}, rv[15:0]} : rv;
        rv = $urandom;
        b4[e*32 +: 32] = mode == 0 ? {{24{rv[7]}}, rv[7:0]} : mode == 1 ? {{16{rv[15]}}, rv[15:0]} : rv;
      end
      model4(a4, b4, e4, eo);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      t = 0;
      while (!m4.in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      in4_valid = 1;
      @(posedge clk);
      #1 in4_valid = 0;
      a4 = {16{$urandom}};
      b4 = {16{$urandom}};
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        #1;
      end while (!m4.out_valid && lat < 200);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      r4 = m4.res;
      o4 = m4.ovf;
      chk($sformatf("n4_%0d_lat", n), lat, 64);
      chk($sformatf("n4_%0d_res", n), r4, e4);
      chk($sformatf("n4_%0d_ovf", n), o4, eo);
      out4_ready = 1;
      @(posedge clk);
      #1 out4_ready = 0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
